// File: rtl/wbc_dbgm.sv
// Debug bus master: turns a UART byte stream into single 16-bit Wishbone
// read/write cycles and answers with read data, ACK (0x06) or NAK (0x15).
module wbc_dbgm #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_vld_i,
    output logic        rx_rdy_o,
    output logic [7:0]  tx_dat_o,
    output logic        tx_vld_o,
    input  logic        tx_rdy_i,
    input  logic        wbm_gnt_i,
    output logic [15:0] wbm_adr_o,
    output logic [15:0] wbm_dat_o,
    input  logic [15:0] wbm_dat_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [1:0]  wbm_sel_o,
    input  logic        wbm_ack_i
);

    typedef enum logic [3:0] {
        IDLE, ADR0, ADR1, DAT0, DAT1, BUS, RSP0, RSP1, NAK
    } state_t;

    localparam logic [7:0]  OP_W   = 8'h57;
    localparam logic [7:0]  OP_B   = 8'h42;
    localparam logic [7:0]  OP_R   = 8'h52;
    localparam logic [7:0]  CH_ACK = 8'h06;
    localparam logic [7:0]  CH_NAK = 8'h15;
    localparam logic [15:0] TMO    = 16'(TIMEOUT);

    state_t      state_q;
    logic [7:0]  op_q;
    logic [15:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic [7:0]  rhi_q;
    logic [15:0] cnt_q, cnt_dec;
    logic        rx_rdy_q, tx_vld_q;
    logic [7:0]  tx_dat_q;
    logic [15:0] wbm_adr_q, wbm_dat_q;
    logic        wbm_cyc_q, wbm_stb_q, wbm_we_q;
    logic [1:0]  wbm_sel_q;
    logic        rx_fire, tx_fire, last_byte, bus_start;

    // Word accesses are forced to an even address; byte writes keep the full address.
    function automatic logic [15:0] bus_adr(input logic [7:0] op, input logic [15:0] a);
        return (op == OP_B) ? a : {a[15:1], 1'b0};
    endfunction

    function automatic logic [1:0] bus_sel(input logic [7:0] op, input logic [15:0] a);
        if (op != OP_B) return 2'b11;
        return a[0] ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [15:0] bus_dat(input logic [7:0] op, input logic [15:0] d);
        return (op == OP_B) ? {d[7:0], d[7:0]} : d;
    endfunction

    assign rx_fire   = rx_vld_i & rx_rdy_q;
    assign tx_fire   = tx_vld_q & tx_rdy_i;
    assign cnt_dec   = cnt_q - 16'd1;
    assign last_byte = rx_fire && ((state_q == ADR1 && op_q == OP_R) ||
                                   (state_q == DAT0 && op_q == OP_B) ||
                                   (state_q == DAT1));
    // Fields are taken from adr_d/dat_d so the byte arriving this edge is included.
    assign bus_start = wbm_gnt_i && !wbm_cyc_q && (last_byte || state_q == BUS);

    always_comb begin
        adr_d = adr_q;
        dat_d = dat_q;
        if (rx_fire) begin
            case (state_q)
                ADR0:    adr_d[7:0]  = rx_dat_i;
                ADR1:    adr_d[15:8] = rx_dat_i;
                DAT0:    dat_d[7:0]  = rx_dat_i;
                DAT1:    dat_d[15:8] = rx_dat_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            op_q      <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rhi_q     <= '0;
            cnt_q     <= '0;
            rx_rdy_q  <= 1'b0;
            tx_vld_q  <= 1'b0;
            tx_dat_q  <= '0;
            wbm_adr_q <= '0;
            wbm_dat_q <= '0;
            wbm_cyc_q <= 1'b0;
            wbm_stb_q <= 1'b0;
            wbm_we_q  <= 1'b0;
            wbm_sel_q <= '0;
        end else begin
            adr_q <= adr_d;
            dat_q <= dat_d;
            case (state_q)
                IDLE: begin
                    rx_rdy_q <= 1'b1;
                    if (rx_fire) begin
                        op_q <= rx_dat_i;
                        if (rx_dat_i == OP_W || rx_dat_i == OP_B || rx_dat_i == OP_R) begin
                            state_q <= ADR0;
                        end else begin
                            state_q  <= NAK;
                            rx_rdy_q <= 1'b0;
                            tx_vld_q <= 1'b1;
                            tx_dat_q <= CH_NAK;
                        end
                    end
                end
                ADR0: if (rx_fire) state_q <= ADR1;
                ADR1: if (rx_fire) begin
                    if (op_q == OP_R) begin
                        state_q  <= BUS;
                        rx_rdy_q <= 1'b0;
                    end else begin
                        state_q <= DAT0;
                    end
                end
                DAT0: if (rx_fire) begin
                    if (op_q == OP_B) begin
                        state_q  <= BUS;
                        rx_rdy_q <= 1'b0;
                    end else begin
                        state_q <= DAT1;
                    end
                end
                DAT1: if (rx_fire) begin
                    state_q  <= BUS;
                    rx_rdy_q <= 1'b0;
                end
                BUS: if (wbm_stb_q) begin
                    // Ack takes priority over an expiring timeout on the same edge.
                    if (wbm_ack_i) begin
                        wbm_cyc_q <= 1'b0;
                        wbm_stb_q <= 1'b0;
                        wbm_we_q  <= 1'b0;
                        rhi_q     <= wbm_dat_i[15:8];
                        state_q   <= RSP0;
                        tx_vld_q  <= 1'b1;
                        tx_dat_q  <= wbm_we_q ? CH_ACK : wbm_dat_i[7:0];
                    end else begin
                        cnt_q <= cnt_dec;
                        if (cnt_dec == '0) begin
                            wbm_cyc_q <= 1'b0;
                            wbm_stb_q <= 1'b0;
                            wbm_we_q  <= 1'b0;
                            state_q   <= NAK;
                            tx_vld_q  <= 1'b1;
                            tx_dat_q  <= CH_NAK;
                        end
                    end
                end
                RSP0: if (tx_fire) begin
                    if (op_q == OP_R) begin
                        state_q  <= RSP1;
                        tx_dat_q <= rhi_q;
                    end else begin
                        state_q  <= IDLE;
                        tx_vld_q <= 1'b0;
                        rx_rdy_q <= 1'b1;
                    end
                end
                RSP1, NAK: if (tx_fire) begin
                    state_q  <= IDLE;
                    tx_vld_q <= 1'b0;
                    rx_rdy_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (bus_start) begin
                wbm_cyc_q <= 1'b1;
                wbm_stb_q <= 1'b1;
                wbm_we_q  <= (op_q != OP_R);
                wbm_adr_q <= bus_adr(op_q, adr_d);
                wbm_sel_q <= bus_sel(op_q, adr_d);
                wbm_dat_q <= bus_dat(op_q, dat_d);
                cnt_q     <= TMO;
            end
        end
    end

    assign rx_rdy_o  = rx_rdy_q;
    assign tx_dat_o  = tx_dat_q;
    assign tx_vld_o  = tx_vld_q;
    assign wbm_adr_o = wbm_adr_q;
    assign wbm_dat_o = wbm_dat_q;
    assign wbm_cyc_o = wbm_cyc_q;
    assign wbm_stb_o = wbm_stb_q;
    assign wbm_we_o  = wbm_we_q;
    assign wbm_sel_o = wbm_sel_q;

endmodule

// File: tb/tb_wbc_dbgm.sv
// Scoreboard bench for wbc_dbgm: commands push expected bus cycles and reply
// bytes; a negedge monitor acts as slave/transmitter and pops and compares.
module tb_wbc_dbgm;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_dat_i = '0;
    logic        rx_vld_i = 1'b0;
    logic        rx_rdy_o;
    logic [7:0]  tx_dat_o;
    logic        tx_vld_o;
    logic        tx_rdy_i = 1'b0;
    logic        wbm_gnt_i = 1'b1;
    logic [15:0] wbm_adr_o, wbm_dat_o;
    logic [15:0] wbm_dat_i = '0;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [1:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;

    wbc_dbgm #(.TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_dat_i(rx_dat_i), .rx_vld_i(rx_vld_i), .rx_rdy_o(rx_rdy_o),
        .tx_dat_o(tx_dat_o), .tx_vld_o(tx_vld_o), .tx_rdy_i(tx_rdy_i),
        .wbm_gnt_i(wbm_gnt_i), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
        logic        we;
        int          dur;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] smem[64];
    logic [15:0] rmem[64];
    int checks = 0;
    int errors = 0;
    int cur_lat = 1;
    int gnt_mode = 1;      // 0 random, 1 high, 2 low
    bit stall_req = 0;
    bit rand_tx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor, slave and transmitter model; all inputs change on the falling edge.
    bit          prev_stb = 0, prev_cyc = 0, prev_vld = 0, prev_hs = 0;
    logic [7:0]  prev_dat = '0;
    int          stb_cnt = 0, slv_wait = 0, stall_cnt = 0;
    bus_t        cap;
    always @(negedge clk) begin
        if (rst) begin
            wbm_ack_i = 1'b0;
            tx_rdy_i  = 1'b0;
            slv_wait  = 0;
            stb_cnt   = 0;
            prev_stb  = 0;
            prev_cyc  = 0;
            prev_vld  = 0;
            prev_hs   = 0;
            stall_cnt = 0;
        end else begin
            if (wbm_cyc_o && !prev_cyc) chk("gnt_at_start", wbm_gnt_i, 1);
            if (wbm_stb_o) begin
                if (!prev_stb) begin
                    cap.adr = wbm_adr_o; cap.dat = wbm_dat_o;
                    cap.sel = wbm_sel_o; cap.we = wbm_we_o;
                    stb_cnt = 0;
                end
                stb_cnt++;
            end else if (prev_stb) begin
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", cap.adr, 32'hFFFF_FFFF);
                end else begin
                    bus_t e;
                    e = exp_bus.pop_front();
                    chk("bus_adr", cap.adr, e.adr);
                    chk("bus_sel", cap.sel, e.sel);
                    chk("bus_we", cap.we, e.we);
                    if (e.we) chk("bus_dat", cap.dat, e.dat);
                    chk("stb_cycles", stb_cnt, e.dur);
                end
            end
            if (wbm_cyc_o && wbm_stb_o && !wbm_adr_o[15] && slv_wait == cur_lat) begin
                wbm_ack_i = 1'b1;
                if (wbm_we_o) begin
                    if (wbm_sel_o[1]) smem[wbm_adr_o[6:1]][15:8] = wbm_dat_o[15:8];
                    if (wbm_sel_o[0]) smem[wbm_adr_o[6:1]][7:0]  = wbm_dat_o[7:0];
                end else begin
                    wbm_dat_i = smem[wbm_adr_o[6:1]];
                end
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = 16'($urandom);
                if (wbm_stb_o) slv_wait++; else slv_wait = 0;
            end

            if (tx_vld_o && prev_vld && !prev_hs) chk("tx_hold", tx_dat_o, prev_dat);
            if (exp_tx.size() > 0 || exp_bus.size() > 0) chk("rx_rdy_busy", rx_rdy_o, 0);
            if (stall_cnt > 0) begin
                tx_rdy_i = 1'b0; stall_cnt--;
            end else if (stall_req && tx_vld_o) begin
                tx_rdy_i = 1'b0; stall_cnt = 9; stall_req = 0;
            end else begin
                tx_rdy_i = rand_tx ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            prev_hs = tx_vld_o && tx_rdy_i;
            if (prev_hs) begin
                if (exp_tx.size() == 0) chk("tx_unexpected", tx_dat_o, 32'hFFFF_FFFF);
                else chk("tx_byte", tx_dat_o, exp_tx.pop_front());
            end
            prev_vld = tx_vld_o;
            prev_dat = tx_dat_o;
            prev_stb = wbm_stb_o;
            prev_cyc = wbm_cyc_o;
        end
        wbm_gnt_i = (gnt_mode == 0) ? ($urandom_range(0, 3) != 0) : (gnt_mode == 1);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_dat_i = b;
        rx_vld_i = 1'b1;
        while (!rx_rdy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("rx_accept_timeout", n, 0);
        @(posedge clk);
        #1 rx_vld_i = 1'b0;
    endtask

    // Reference model: expected bus cycle and reply bytes straight from the command rules.
    task automatic issue_cmd(input logic [7:0] op, input logic [7:0] alo, ahi, dlo, dhi);
        logic [15:0] a;
        bus_t        e;
        bit          ok;
        logic [7:0]  rsp[$];
        int          nb;
        a = {ahi, alo};
        ok = !a[15] && cur_lat < TMO;
        e.dur = ok ? cur_lat + 1 : TMO;
        e.dat = '0;
        case (op)
            8'h57: begin
                nb = 5; e.adr = a & 16'hFFFE; e.dat = {dhi, dlo}; e.sel = 2'b11; e.we = 1'b1;
                if (ok) rmem[a[6:1]] = {dhi, dlo};
                rsp.push_back(ok ? 8'h06 : 8'h15);
            end
            8'h42: begin
                nb = 4; e.adr = a; e.dat = {dlo, dlo}; e.sel = a[0] ? 2'b10 : 2'b01; e.we = 1'b1;
                if (ok && a[0]) rmem[a[6:1]][15:8] = dlo;
                if (ok && !a[0]) rmem[a[6:1]][7:0] = dlo;
                rsp.push_back(ok ? 8'h06 : 8'h15);
            end
            8'h52: begin
                nb = 3; e.adr = a & 16'hFFFE; e.sel = 2'b11; e.we = 1'b0;
                if (ok) begin
                    rsp.push_back(rmem[a[6:1]][7:0]);
                    rsp.push_back(rmem[a[6:1]][15:8]);
                end else begin
                    rsp.push_back(8'h15);
                end
            end
            default: begin
                nb = 1; e.adr = '0; e.sel = '0; e.we = 1'b0;
                rsp.push_back(8'h15);
            end
        endcase
        send_byte(op);
        if (nb > 1) send_byte(alo);
        if (nb > 2) send_byte(ahi);
        if (nb > 3) send_byte(dlo);
        if (nb > 4) send_byte(dhi);
        if (nb > 1) exp_bus.push_back(e);
        foreach (rsp[i]) exp_tx.push_back(rsp[i]);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_tx.size() > 0 || exp_bus.size() > 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            chk("response_timeout", n, 0);
            exp_tx.delete();
            exp_bus.delete();
        end
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [7:0] alo, ahi, dlo, dhi);
        issue_cmd(op, alo, ahi, dlo, dhi);
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            smem[i] = 16'($urandom);
            rmem[i] = smem[i];
        end
        #3;
        chk("rst_cyc", wbm_cyc_o, 0);
        chk("rst_stb", wbm_stb_o, 0);
        chk("rst_tx_vld", tx_vld_o, 0);
        chk("rst_rx_rdy", rx_rdy_o, 0);
        chk("rst_adr", wbm_adr_o, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 chk("rx_rdy_after_rst", rx_rdy_o, 1);

        cur_lat = 1;
        run_cmd(8'h57, 8'h10, 8'h02, 8'h34, 8'h12);
        smem[16] = 16'hBEEF;
        rmem[16] = 16'hBEEF;
        cur_lat = 0;
        run_cmd(8'h52, 8'h21, 8'h00, 8'h00, 8'h00);
        stall_req = 1;
        run_cmd(8'h52, 8'h21, 8'h00, 8'h00, 8'h00);
        cur_lat = 2;
        run_cmd(8'h42, 8'h01, 8'h04, 8'hA5, 8'h00);
        run_cmd(8'h42, 8'h00, 8'h04, 8'h5A, 8'h00);
        run_cmd(8'h52, 8'h00, 8'h04, 8'h00, 8'h00);
        run_cmd(8'h52, 8'h00, 8'h80, 8'h00, 8'h00);
        cur_lat = 7;
        run_cmd(8'h52, 8'h10, 8'h02, 8'h00, 8'h00);

        cur_lat = 0;
        gnt_mode = 2;
        @(negedge clk);
        issue_cmd(8'h57, 8'h06, 8'h00, 8'hCD, 8'hAB);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1 chk("cyc_without_gnt", wbm_cyc_o, 0);
        end
        gnt_mode = 1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("cyc_after_gnt", wbm_cyc_o, 1);
        wait_done();
        run_cmd(8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
        run_cmd(8'h52, 8'h06, 8'h00, 8'h00, 8'h00);

        cur_lat = 6;
        issue_cmd(8'h52, 8'h08, 8'h00, 8'h00, 8'h00);
        begin
            int n = 0;
            while (!wbm_stb_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("stb_before_reset", wbm_stb_o, 1);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cyc", wbm_cyc_o, 0);
        chk("mid_rst_stb", wbm_stb_o, 0);
        chk("mid_rst_tx_vld", tx_vld_o, 0);
        exp_bus.delete();
        exp_tx.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        cur_lat = 1;
        run_cmd(8'h52, 8'h08, 8'h00, 8'h00, 8'h00);

        gnt_mode = 0;
        rand_tx = 1;
        for (int k = 0; k < 150; k++) begin
            logic [7:0]  op;
            logic [15:0] a;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do op = 8'($urandom); while (op == 8'h57 || op == 8'h42 || op == 8'h52);
            end else if (r <= 3) op = 8'h57;
            else if (r <= 6) op = 8'h42;
            else op = 8'h52;
            if ($urandom_range(0, 9) == 0) a = 16'h8000 | 16'($urandom);
            else a = 16'($urandom) & 16'h007F;
            cur_lat = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) stall_req = 1;
            run_cmd(op, a[7:0], a[15:8], 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/wbc_dbgm.md
Name: wbc_dbgm

Overview:
- Byte-stream driven Wishbone bus master used for debug, memory loading and inspection over a serial link.
- Accepts command bytes from a UART receiver byte interface and executes single 16-bit Wishbone read/write cycles on the system bus. Shares the bus with the CPU via a grant input.
- Returns read data or status bytes through a byte interface to a UART transmitter.
- A bus timeout guards against unmapped addresses that never acknowledge.

Parameters:
- TIMEOUT, 255: max cycles stb may stay asserted without ack before the cycle is abandoned (1..65535).

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- rx_dat_i  in  8  command byte from receiver
- rx_vld_i  in  1  rx_dat_i valid
- rx_rdy_o  out 1  block can accept a byte; transfer on edge with rx_vld_i & rx_rdy_o
- tx_dat_o  out 8  response byte to transmitter
- tx_vld_o  out 1  tx_dat_o valid, held until accepted
- tx_rdy_i  in  1  transmitter accepts; transfer on edge with tx_vld_o & tx_rdy_i
- wbm_gnt_i in  1  bus granted to this master
- wbm_adr_o out 16 bus address
- wbm_dat_o out 16 write data
- wbm_dat_i in  16 read data
- wbm_cyc_o out 1  bus cycle
- wbm_stb_o out 1  strobe
- wbm_we_o  out 1  1 = write
- wbm_sel_o out 2  byte lanes
- wbm_ack_i in  1  acknowledge

Behaviour:
- All outputs are registered. Reset (async) forces every output to 0, state to IDLE and timeout counter to 0. rx_rdy_o goes to 1 on the first edge after reset release.
- Commands (all multi-byte fields low byte first):
  - 0x57 'W' word write: adr_lo adr_hi dat_lo dat_hi.
  - 0x42 'B' byte write: adr_lo adr_hi dat.
  - 0x52 'R' word read: adr_lo adr_hi.
- States: IDLE, ADR0, ADR1, DAT0, DAT1, BUS, RSP0, RSP1, NAK.
  - IDLE: accept opcode. 'W'/'B'/'R' -> ADR0. Any other opcode -> NAK.
  - ADR0 -> ADR1.
  - ADR1: 'R' -> BUS; 'W'/'B' -> DAT0.
  - DAT0: 'B' -> BUS; 'W' -> DAT1.
  - DAT1 -> BUS.
- rx_rdy_o is registered from next state: 1 in IDLE..DAT1, 0 in BUS/RSP*/NAK. No byte is accepted while a response is pending.
- Bus field encoding:
  - 'W': adr = {adr_hi, adr_lo[7:1], 0}, sel = 11, dat = {dat_hi, dat_lo}.
  - 'R': adr = {adr_hi, adr_lo[7:1], 0}, sel = 11, we = 0.
  - 'B': adr = full 16-bit address, dat = {dat, dat}, sel = adr[0] ? 10 : 01.
- Bus cycle start:
  - cyc/stb/we/sel/adr/dat are set on the edge that enters BUS if wbm_gnt_i is high.
  - Otherwise they are set on the first later edge with wbm_gnt_i high.
  - Once asserted, cyc and stb stay high irrespective of wbm_gnt_i until termination.
- Timeout counter loads TIMEOUT when stb rises and decrements each cycle stb is high with no ack.
- Termination:
  - ack sampled high: cyc, stb and we drop on that same edge, so there is exactly one ack per cycle. For reads, wbm_dat_i is captured on that edge.
  - Counter reaches 0 with no ack: cycle is dropped and state -> NAK.
  - ack and counter==0 on the same edge: ack wins.
- Responses:
  - Write ok: RSP0 with tx_dat_o = 0x06 (ACK), then IDLE.
  - Read ok: RSP0 sends data[7:0], then RSP1 sends data[15:8], then IDLE.
  - NAK: tx_dat_o = 0x15, then IDLE.
  - tx_vld_o rises on the edge entering a response state. tx_dat_o is stable while tx_vld_o is high. tx_vld_o falls on the handshake edge unless another byte follows (RSP0 -> RSP1 keeps tx_vld_o high and updates data).
- Reset mid-operation (including mid bus cycle) immediately deasserts cyc/stb and tx_vld_o. No partial response is sent.
- A unknown opcode consumes only that single byte.

Test Plan:
- Word write: rx 57 10 02 34 12, gnt=1, slave acks on 2nd stb cycle -> one bus cycle adr=0x0210, dat=0x1234, sel=11, we=1; tx byte 0x06; rx_rdy_o low from last byte until tx handshake.
- Word read with odd address: rx 52 21 00, slave returns 0xBEEF with ack -> adr=0x0020, sel=11, we=0; tx bytes EF then BE. Repeat with tx_rdy_i held low 10 cycles -> tx_dat_o holds 0xEF, no loss.
- Byte write odd/even: rx 42 01 04 A5 -> adr=0x0401, sel=10, dat=0xA5A5; rx 42 00 04 5A -> sel=01; tx 06 each.
- Timeout: TIMEOUT=8, read of unmapped address with no ack -> stb high exactly 8 cycles then dropped; tx 0x15 only. Ack forced on 8th cycle -> data response, no NAK.
- Grant and bad opcode: gnt=0 for 20 cycles after command -> cyc stays 0, then cycle starts the edge after gnt rises. rx 0x33 -> tx 0x15, next byte treated as opcode.
- Async reset asserted mid bus cycle (stb high) -> cyc/stb/tx_vld_o 0 without clock edge; after release, new 'R' command completes normally.
